// File: rtl/muldiv_hilo_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit.
package muldiv_hilo_pkg;

    localparam int unsigned MC_W     = 4;
    localparam int unsigned MC_MULT  = 0;
    localparam int unsigned MC_MULTU = 1;
    localparam int unsigned MC_DIV   = 2;
    localparam int unsigned MC_DIVU  = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DZ   = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        OP_MULT  = 2'd0,
        OP_MULTU = 2'd1,
        OP_DIV   = 2'd2,
        OP_DIVU  = 2'd3
    } op_e;

    // Resolve mul_control to a single op; lower bit positions win when several are set.
    function automatic op_e mc_decode(input logic [MC_W-1:0] mc);
        if (mc[MC_MULT]) begin
            return OP_MULT;
        end else if (mc[MC_MULTU]) begin
            return OP_MULTU;
        end else if (mc[MC_DIV]) begin
            return OP_DIV;
        end
        return OP_DIVU;
    endfunction

endpackage

// File: rtl/muldiv_hilo_if.sv
// Request / HI-LO bus between the EX stage and the multiply/divide unit.
interface muldiv_hilo_if
    import muldiv_hilo_pkg::*;
#(
    parameter int unsigned XLEN = 32
);
    logic [MC_W-1:0] mc;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic            wr_hi;
    logic            wr_lo;
    logic [XLEN-1:0] wr_data;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;

    modport master (
        output mc, in_valid, src_a, src_b, wr_hi, wr_lo, wr_data, flush,
        input  in_ready, busy, done, hi, lo
    );

    modport slave (
        input  mc, in_valid, src_a, src_b, wr_hi, wr_lo, wr_data, flush,
        output in_ready, busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_hilo_div_iter.sv
// Restoring radix-2 divider on unsigned magnitudes, one quotient bit per cycle.
module muldiv_hilo_div_iter #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic            abort_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic            vld_o,
    output logic [XLEN-1:0] quo_o,
    output logic [XLEN-1:0] rem_o
);
    localparam int unsigned CNT_W = $clog2(XLEN + 1);

    logic             busy_q, busy_d;
    logic             vld_q, vld_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  quo_q, quo_d;
    logic [XLEN-1:0]  rem_q, rem_d;
    logic [XLEN-1:0]  dvs_q, dvs_d;
    logic [XLEN:0]    rem_sh;
    logic [XLEN:0]    diff;

    assign rem_sh = {rem_q, quo_q[XLEN-1]};
    assign diff   = rem_sh - {1'b0, dvs_q};

    // Load on start, then shift-subtract; vld pulses for one cycle after the last bit.
    always_comb begin
        busy_d = busy_q;
        vld_d  = 1'b0;
        cnt_d  = cnt_q;
        quo_d  = quo_q;
        rem_d  = rem_q;
        dvs_d  = dvs_q;
        if (abort_i) begin
            busy_d = 1'b0;
        end else if (start_i) begin
            busy_d = 1'b1;
            cnt_d  = CNT_W'(XLEN);
            quo_d  = dividend_i;
            rem_d  = '0;
            dvs_d  = divisor_i;
        end else if (busy_q) begin
            if (diff[XLEN]) begin
                rem_d = rem_sh[XLEN-1:0];
                quo_d = {quo_q[XLEN-2:0], 1'b0};
            end else begin
                rem_d = diff[XLEN-1:0];
                quo_d = {quo_q[XLEN-2:0], 1'b1};
            end
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                busy_d = 1'b0;
                vld_d  = 1'b1;
            end
        end
    end

    // Divider state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= 1'b0;
            vld_q  <= 1'b0;
            cnt_q  <= '0;
            quo_q  <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
        end else begin
            busy_q <= busy_d;
            vld_q  <= vld_d;
            cnt_q  <= cnt_d;
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            dvs_q  <= dvs_d;
        end
    end

    assign vld_o = vld_q;
    assign quo_o = quo_q;
    assign rem_o = rem_q;

endmodule

// File: rtl/muldiv_hilo.sv
// Multi-cycle multiply/divide unit owning the HI/LO register pair.
module muldiv_hilo
    import muldiv_hilo_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned MUL_LAT = 2
) (
    input  logic           clk,
    input  logic           rst,
    muldiv_hilo_if.slave   bus
);
    localparam int unsigned PW    = 2 * XLEN;
    localparam int unsigned CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [XLEN-1:0]  a_q, a_d, b_q, b_d;
    logic [XLEN-1:0]  hi_q, hi_d, lo_q, lo_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             accept, sel_div, sel_signed, div_start, div_abort;
    op_e              op_sel;
    logic [XLEN-1:0]  mag_a, mag_b, div_quo, div_rem, quo_fix, rem_fix;
    logic             div_vld, quo_neg, rem_neg;
    logic [PW-1:0]    a_ext, b_ext, prod;

    assign accept     = bus.in_valid && (state_q == ST_IDLE) && (|bus.mc) && !bus.flush;
    assign op_sel     = mc_decode(bus.mc);
    assign sel_div    = (op_sel == OP_DIV) || (op_sel == OP_DIVU);
    assign sel_signed = (op_sel == OP_DIV);
    assign mag_a      = (sel_signed && bus.src_a[XLEN-1]) ? (~bus.src_a + XLEN'(1)) : bus.src_a;
    assign mag_b      = (sel_signed && bus.src_b[XLEN-1]) ? (~bus.src_b + XLEN'(1)) : bus.src_b;

    // Two's-complement product of the sign- or zero-extended latched operands.
    assign a_ext = (op_q == OP_MULT) ? {{XLEN{a_q[XLEN-1]}}, a_q} : {{XLEN{1'b0}}, a_q};
    assign b_ext = (op_q == OP_MULT) ? {{XLEN{b_q[XLEN-1]}}, b_q} : {{XLEN{1'b0}}, b_q};
    assign prod  = a_ext * b_ext;

    // Sign fix-up of the magnitude result; MIN/-1 wraps back to MIN naturally.
    assign quo_neg = (op_q == OP_DIV) && (a_q[XLEN-1] ^ b_q[XLEN-1]);
    assign rem_neg = (op_q == OP_DIV) && a_q[XLEN-1];
    assign quo_fix = quo_neg ? (~div_quo + XLEN'(1)) : div_quo;
    assign rem_fix = rem_neg ? (~div_rem + XLEN'(1)) : div_rem;

    muldiv_hilo_div_iter #(.XLEN(XLEN)) u_div_iter (
        .clk        (clk),
        .rst        (rst),
        .start_i    (div_start),
        .abort_i    (div_abort),
        .dividend_i (mag_a),
        .divisor_i  (mag_b),
        .vld_o      (div_vld),
        .quo_o      (div_quo),
        .rem_o      (div_rem)
    );

    // Next-state, HI/LO update and done generation.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        cnt_d     = cnt_q;
        div_start = 1'b0;
        div_abort = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.wr_hi) hi_d = bus.wr_data;
                if (bus.wr_lo) lo_d = bus.wr_data;
                if (accept) begin
                    op_d = op_sel;
                    a_d  = bus.src_a;
                    b_d  = bus.src_b;
                    if (!sel_div) begin
                        state_d = ST_MUL;
                        cnt_d   = CNT_W'(MUL_LAT - 1);
                    end else if (bus.src_b == '0) begin
                        state_d = ST_DZ;
                    end else begin
                        state_d   = ST_DIV;
                        div_start = 1'b1;
                    end
                end
            end
            ST_MUL: begin
                if (bus.flush) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == '0) begin
                    hi_d    = prod[PW-1:XLEN];
                    lo_d    = prod[XLEN-1:0];
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DIV: begin
                if (bus.flush) begin
                    state_d   = ST_IDLE;
                    div_abort = 1'b1;
                end else if (div_vld) begin
                    hi_d    = rem_fix;
                    lo_d    = quo_fix;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_DZ: begin
                state_d = ST_IDLE;
                if (!bus.flush) begin
                    hi_d   = a_q;
                    lo_d   = '1;
                    done_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= OP_MULT;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.in_ready = (state_q == ST_IDLE);
    assign bus.busy     = (state_q != ST_IDLE);
    assign bus.done     = done_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;

endmodule

// File: tb/tb_muldiv_hilo.sv
// Directed bench for muldiv_hilo with hand-computed expectations.
module tb_muldiv_hilo;
    localparam int unsigned XLEN    = 32;
    localparam int unsigned MUL_LAT = 2;
    localparam int          TMO     = 200;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    muldiv_hilo_if #(.XLEN(XLEN)) bus();

    muldiv_hilo #(.XLEN(XLEN), .MUL_LAT(MUL_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (bus.done !== 1'b1 && lat < TMO) begin
            step();
            lat++;
        end
    endtask

    // Issue one op, scramble operands after accept, then check latency and HI/LO.
    task automatic run_op(input string tag, input logic [3:0] mc, input logic [31:0] a,
                          input logic [31:0] b, input int exp_lat,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int lat;
        bus.mc       = mc;
        bus.in_valid = 1'b1;
        bus.src_a    = a;
        bus.src_b    = b;
        step();
        bus.in_valid = 1'b0;
        bus.mc       = '0;
        bus.src_a    = 32'hA5A5_5A5A;
        bus.src_b    = 32'h0000_0000;
        check({tag, "_busy"}, 64'(bus.busy), 64'd1);
        check({tag, "_done_lo"}, 64'(bus.done), 64'd0);
        wait_done(lat);
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check({tag, "_hi"}, 64'(bus.hi), 64'(exp_hi));
        check({tag, "_lo"}, 64'(bus.lo), 64'(exp_lo));
    endtask

    initial begin
        int lat;
        int pulses;
        bus.mc = '0; bus.in_valid = 1'b0; bus.src_a = '0; bus.src_b = '0;
        bus.wr_hi = 1'b0; bus.wr_lo = 1'b0; bus.wr_data = '0; bus.flush = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        step();
        check("rst_hi", 64'(bus.hi), 64'd0);
        check("rst_lo", 64'(bus.lo), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_ready", 64'(bus.in_ready), 64'd1);
        check("rst_busy", 64'(bus.busy), 64'd0);

        // Multiply and divide results, back to back.
        run_op("mult",  4'b0001, 32'hFFFF_FFFE, 32'h0000_0003, 2,  32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_op("multu", 4'b0010, 32'hFFFF_FFFE, 32'h0000_0003, 2,  32'h0000_0002, 32'hFFFF_FFFA);
        run_op("div_n7_2", 4'b0100, 32'hFFFF_FFF9, 32'h0000_0002, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_7_n2", 4'b0100, 32'h0000_0007, 32'hFFFF_FFFE, 33, 32'h0000_0001, 32'hFFFF_FFFD);
        run_op("divu_big", 4'b1000, 32'h8000_0000, 32'h0000_0010, 33, 32'h0000_0000, 32'h0800_0000);
        run_op("div_ovf",  4'b0100, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h0000_0000, 32'h8000_0000);
        run_op("prio_mul", 4'b0101, 32'hFFFF_FFFE, 32'h0000_0003, 2,  32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_op("prio_div", 4'b1100, 32'hFFFF_FFF9, 32'h0000_0002, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu_z",   4'b1000, 32'h0000_0005, 32'h0000_0000, 1,  32'h0000_0005, 32'hFFFF_FFFF);

        // mthi dropped while dividing, then flush at iteration 10.
        bus.mc = 4'b1000; bus.in_valid = 1'b1; bus.src_a = 32'd100; bus.src_b = 32'd7;
        step();
        bus.in_valid = 1'b0; bus.mc = '0;
        bus.wr_hi = 1'b1; bus.wr_data = 32'h0000_1234;
        step();
        bus.wr_hi = 1'b0;
        check("mthi_drop", 64'(bus.hi), 64'h5);
        repeat (8) step();
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        check("dflush_ready", 64'(bus.in_ready), 64'd1);
        check("dflush_done", 64'(bus.done), 64'd0);
        check("dflush_hi", 64'(bus.hi), 64'h5);
        check("dflush_lo", 64'(bus.lo), 64'hFFFF_FFFF);
        pulses = 0;
        repeat (40) begin
            step();
            if (bus.done === 1'b1) pulses++;
        end
        check("dflush_nodone", 64'(pulses), 64'd0);

        // Flush on the completing cycle of a divide-by-zero.
        bus.mc = 4'b1000; bus.in_valid = 1'b1; bus.src_a = 32'd9; bus.src_b = 32'd0;
        step();
        bus.in_valid = 1'b0; bus.mc = '0; bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        check("dzflush_done", 64'(bus.done), 64'd0);
        check("dzflush_hi", 64'(bus.hi), 64'h5);
        check("dzflush_ready", 64'(bus.in_ready), 64'd1);

        // Flush during multiply.
        bus.mc = 4'b0001; bus.in_valid = 1'b1; bus.src_a = 32'd3; bus.src_b = 32'd4;
        step();
        bus.in_valid = 1'b0; bus.mc = '0;
        step();
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        check("mflush_done", 64'(bus.done), 64'd0);
        check("mflush_lo", 64'(bus.lo), 64'hFFFF_FFFF);

        // mthi / mtlo in IDLE, including with flush and an ignored mc==0 request.
        bus.wr_hi = 1'b1; bus.wr_data = 32'h0000_AAAA;
        step();
        bus.wr_hi = 1'b0;
        check("mthi", 64'(bus.hi), 64'hAAAA);
        bus.wr_hi = 1'b1; bus.wr_lo = 1'b1; bus.wr_data = 32'h0000_0055;
        step();
        bus.wr_hi = 1'b0; bus.wr_lo = 1'b0;
        check("mthilo_hi", 64'(bus.hi), 64'h55);
        check("mthilo_lo", 64'(bus.lo), 64'h55);
        bus.mc = 4'b0001; bus.in_valid = 1'b1; bus.flush = 1'b1;
        bus.wr_lo = 1'b1; bus.wr_data = 32'h0000_0077;
        step();
        bus.in_valid = 1'b0; bus.mc = '0; bus.flush = 1'b0; bus.wr_lo = 1'b0;
        check("iflush_ready", 64'(bus.in_ready), 64'd1);
        check("iflush_mtlo", 64'(bus.lo), 64'h77);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        check("mc0_ignored", 64'(bus.in_ready), 64'd1);

        // mthi and mult accepted on the same edge.
        bus.wr_hi = 1'b1; bus.wr_data = 32'h0000_DEAD;
        bus.mc = 4'b0001; bus.in_valid = 1'b1; bus.src_a = 32'd3; bus.src_b = 32'd4;
        step();
        bus.wr_hi = 1'b0; bus.mc = '0; bus.in_valid = 1'b0;
        check("mthi_now", 64'(bus.hi), 64'hDEAD);
        wait_done(lat);
        check("mthi_mult_lat", 64'(lat), 64'(MUL_LAT));
        check("mthi_mult_hi", 64'(bus.hi), 64'h0);
        check("mthi_mult_lo", 64'(bus.lo), 64'd12);

        // Asynchronous reset in the middle of a divide.
        bus.mc = 4'b0100; bus.in_valid = 1'b1; bus.src_a = 32'd1000; bus.src_b = 32'd3;
        step();
        bus.in_valid = 1'b0; bus.mc = '0;
        repeat (5) step();
        #2 rst = 1'b1;
        #1;
        check("arst_hi", 64'(bus.hi), 64'h0);
        check("arst_lo", 64'(bus.lo), 64'h0);
        check("arst_ready", 64'(bus.in_ready), 64'd1);
        check("arst_done", 64'(bus.done), 64'd0);
        step();
        rst = 1'b0;
        step();
        run_op("post_rst", 4'b1000, 32'd100, 32'd7, 33, 32'd2, 32'd14);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
